// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - read-during-write mode constants and the byte-lane merge helper
package sram_pkg;

  localparam logic [1:0] RDW_READ_FIRST  = 2'd0;
  localparam logic [1:0] RDW_WRITE_FIRST = 2'd1;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W  = 1024;
  localparam int MERGE_NB = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_NB-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int k = 0; k < MERGE_NB; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_rd_port.sv
// rtl/sram_rd_port.sv - one read port: write-address compare, bypass mux, data/valid registers
// Optional extra output stage when SRAM_DP_OUTREG_EN is defined.
module sram_rd_port
  import sram_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter int         DEPTH_LOG = 4,
  parameter int         NB        = WIDTH / 8,
  parameter logic [1:0] RDW_MODE  = RDW_READ_FIRST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read,
  input  logic [DEPTH_LOG-1:0] rd_addr,
  input  logic [WIDTH-1:0]     rd_word,
  input  logic                 wr_en_A,
  input  logic [DEPTH_LOG-1:0] wr_addr_A,
  input  logic [NB-1:0]        wr_be_A,
  input  logic [WIDTH-1:0]     wr_data_A,
  input  logic                 wr_en_B,
  input  logic [DEPTH_LOG-1:0] wr_addr_B,
  input  logic [NB-1:0]        wr_be_B,
  input  logic [WIDTH-1:0]     wr_data_B,
  output logic [WIDTH-1:0]     data_rd,
  output logic                 valid
);

  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NB-1:0]    be
  );
    return WIDTH'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_word), MERGE_NB'(be)));
  endfunction

  logic             hit_A;
  logic             hit_B;
  logic [NB-1:0]    hit_be_A;
  logic [NB-1:0]    hit_be_B;
  logic [WIDTH-1:0] bypass_word;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  assign hit_A = wr_en_A && (wr_addr_A == rd_addr);
  assign hit_B = wr_en_B && (wr_addr_B == rd_addr);

  // Write byte enables arrive already collision-resolved, so merge order does not matter.
  assign hit_be_A    = hit_A ? wr_be_A : '0;
  assign hit_be_B    = hit_B ? wr_be_B : '0;
  assign bypass_word = lane_merge(lane_merge(rd_word, wr_data_A, hit_be_A), wr_data_B, hit_be_B);
  assign next_word   = (RDW_MODE == RDW_WRITE_FIRST) ? bypass_word : rd_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= read;
      if (read) begin
        data_q <= next_word;
      end
    end
  end

`ifdef SRAM_DP_OUTREG_EN
  logic [WIDTH-1:0] data_q2;
  logic             valid_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q2  <= '0;
      valid_q2 <= 1'b0;
    end else begin
      data_q2  <= data_q;
      valid_q2 <= valid_q;
    end
  end

  assign data_rd = data_q2;
  assign valid   = valid_q2;
`else
  assign data_rd = data_q;
  assign valid   = valid_q;
`endif

endmodule

// File: rtl/sram_dp_syncread_be.sv
// rtl/sram_dp_syncread_be.sv - true dual-port sync-read SRAM with byte enables and collision resolution
// Define SRAM_DP_OUTREG_EN for an extra output register stage (2-cycle latency).
module sram_dp_syncread_be
  import sram_pkg::*;
#(
  parameter int         WIDTH         = 32,
  parameter int         DEPTH         = 16,
  parameter int         DEPTH_LOG     = $clog2(DEPTH),
  parameter int         NB            = WIDTH / 8,
  parameter logic [1:0] RDW_MODE      = RDW_READ_FIRST,
  parameter int         WR_PRIORITY_A = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_A,
  input  logic                 write_B,
  input  logic                 read_A,
  input  logic                 read_B,
  input  logic [NB-1:0]        be_A,
  input  logic [NB-1:0]        be_B,
  input  logic [DEPTH_LOG-1:0] addr_A,
  input  logic [DEPTH_LOG-1:0] addr_B,
  input  logic [WIDTH-1:0]     data_wr_A,
  input  logic [WIDTH-1:0]     data_wr_B,
  output logic [WIDTH-1:0]     data_rd_A,
  output logic [WIDTH-1:0]     data_rd_B,
  output logic                 valid_A,
  output logic                 valid_B,
  output logic                 collision
);

  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [NB-1:0]    be
  );
    return WIDTH'(byte_merge(MERGE_W'(old_word), MERGE_W'(new_word), MERGE_NB'(be)));
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic             in_range_A;
  logic             in_range_B;
  logic             wr_ok_A;
  logic             wr_ok_B;
  logic             same_addr;
  logic             collision_now;
  logic             collision_q;
  logic [NB-1:0]    eff_be_A;
  logic [NB-1:0]    eff_be_B;
  logic [NB-1:0]    cross_be_A;
  logic [NB-1:0]    cross_be_B;
  logic [WIDTH-1:0] old_A;
  logic [WIDTH-1:0] old_B;
  logic [WIDTH-1:0] new_A;
  logic [WIDTH-1:0] new_B;

  // Addresses past DEPTH only exist for non-power-of-two depths; they never write and read as 0.
  assign in_range_A = int'(addr_A) < DEPTH;
  assign in_range_B = int'(addr_B) < DEPTH;
  assign wr_ok_A    = write_A && !reset && in_range_A;
  assign wr_ok_B    = write_B && !reset && in_range_B;

  assign same_addr     = wr_ok_A && wr_ok_B && (addr_A == addr_B);
  assign collision_now = same_addr && (|(be_A & be_B));

  // Strip the losing port's overlapping lanes so both ports can be applied independently.
  always_comb begin
    eff_be_A = wr_ok_A ? be_A : '0;
    eff_be_B = wr_ok_B ? be_B : '0;
    if (same_addr) begin
      if (WR_PRIORITY_A != 0) begin
        eff_be_B = eff_be_B & ~be_A;
      end else begin
        eff_be_A = eff_be_A & ~be_B;
      end
    end
  end

  assign old_A = in_range_A ? mem[addr_A] : '0;
  assign old_B = in_range_B ? mem[addr_B] : '0;

  // On a shared address each port's word also carries the other's lanes, so both writes agree.
  assign cross_be_A = same_addr ? eff_be_A : '0;
  assign cross_be_B = same_addr ? eff_be_B : '0;
  assign new_A = lane_merge(lane_merge(old_A, data_wr_A, eff_be_A), data_wr_B, cross_be_B);
  assign new_B = lane_merge(lane_merge(old_B, data_wr_B, eff_be_B), data_wr_A, cross_be_A);

  always_ff @(posedge clk) begin
    if (wr_ok_A) begin
      mem[addr_A] <= new_A;
    end
    if (wr_ok_B) begin
      mem[addr_B] <= new_B;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_now;
    end
  end

`ifdef SRAM_DP_OUTREG_EN
  logic collision_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      collision_q2 <= 1'b0;
    end else begin
      collision_q2 <= collision_q;
    end
  end

  assign collision = collision_q2;
`else
  assign collision = collision_q;
`endif

  sram_rd_port #(
    .WIDTH    (WIDTH),
    .DEPTH_LOG(DEPTH_LOG),
    .NB       (NB),
    .RDW_MODE (RDW_MODE)
  ) u_rd_A (
    .clk      (clk),
    .reset    (reset),
    .read     (read_A),
    .rd_addr  (addr_A),
    .rd_word  (old_A),
    .wr_en_A  (wr_ok_A),
    .wr_addr_A(addr_A),
    .wr_be_A  (eff_be_A),
    .wr_data_A(data_wr_A),
    .wr_en_B  (wr_ok_B),
    .wr_addr_B(addr_B),
    .wr_be_B  (eff_be_B),
    .wr_data_B(data_wr_B),
    .data_rd  (data_rd_A),
    .valid    (valid_A)
  );

  sram_rd_port #(
    .WIDTH    (WIDTH),
    .DEPTH_LOG(DEPTH_LOG),
    .NB       (NB),
    .RDW_MODE (RDW_MODE)
  ) u_rd_B (
    .clk      (clk),
    .reset    (reset),
    .read     (read_B),
    .rd_addr  (addr_B),
    .rd_word  (old_B),
    .wr_en_A  (wr_ok_A),
    .wr_addr_A(addr_A),
    .wr_be_A  (eff_be_A),
    .wr_data_A(data_wr_A),
    .wr_en_B  (wr_ok_B),
    .wr_addr_B(addr_B),
    .wr_be_B  (eff_be_B),
    .wr_data_B(data_wr_B),
    .data_rd  (data_rd_B),
    .valid    (valid_B)
  );

endmodule

// File: tb/tb_sram_dp_syncread_be.sv
// tb/tb_sram_dp_syncread_be.sv - scoreboard bench: READ_FIRST/prio-A depth 16 and WRITE_FIRST/prio-B depth 12
module tb_sram_dp_syncread_be;

`ifdef SRAM_DP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH0 = 16;
  localparam int DEPTH1 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, write_A, write_B, read_A, read_B;
  logic [3:0]  be_A, be_B, addr_A, addr_B;
  logic [31:0] data_wr_A, data_wr_B;
  logic [31:0] rd_A0, rd_B0, rd_A1, rd_B1;
  logic        v_A0, v_B0, v_A1, v_B1, coll0, coll1;

  sram_dp_syncread_be #(.WIDTH(32), .DEPTH(DEPTH0)) dut0 (
    .clk(clk), .reset(reset), .write_A(write_A), .write_B(write_B),
    .read_A(read_A), .read_B(read_B), .be_A(be_A), .be_B(be_B),
    .addr_A(addr_A), .addr_B(addr_B), .data_wr_A(data_wr_A), .data_wr_B(data_wr_B),
    .data_rd_A(rd_A0), .data_rd_B(rd_B0), .valid_A(v_A0), .valid_B(v_B0), .collision(coll0)
  );

  sram_dp_syncread_be #(.WIDTH(32), .DEPTH(DEPTH1), .RDW_MODE(sram_pkg::RDW_WRITE_FIRST),
                        .WR_PRIORITY_A(0)) dut1 (
    .clk(clk), .reset(reset), .write_A(write_A), .write_B(write_B),
    .read_A(read_A), .read_B(read_B), .be_A(be_A), .be_B(be_B),
    .addr_A(addr_A), .addr_B(addr_B), .data_wr_A(data_wr_A), .data_wr_B(data_wr_B),
    .data_rd_A(rd_A1), .data_rd_B(rd_B1), .valid_A(v_A1), .valid_B(v_B1), .collision(coll1)
  );

  logic [31:0] rd_w [4];
  logic        v_w  [4];
  logic        c_w  [2];
  assign rd_w[0] = rd_A0;
  assign rd_w[1] = rd_B0;
  assign rd_w[2] = rd_A1;
  assign rd_w[3] = rd_B1;
  assign v_w[0]  = v_A0;
  assign v_w[1]  = v_B0;
  assign v_w[2]  = v_A1;
  assign v_w[3]  = v_B1;
  assign c_w[0]  = coll0;
  assign c_w[1]  = coll1;

  // Reference memory as bytes per word; expected read queues are ring buffers tagged by edge index.
  logic [7:0]  mdl  [2][16][4];
  logic [31:0] rbuf [4][64];
  int          rtag [4][64];
  int          rwp  [4];
  int          rrp  [4];
  logic        cbuf [2][64];
  int          cwp  [2];
  int          crp  [2];
  logic [31:0] last [4];
  int          cyc;
  int          checks;
  int          errors;
  logic        mon_en;

  function automatic string pname(input int p);
    case (p)
      0:       return "dut0.A";
      1:       return "dut0.B";
      2:       return "dut1.A";
      default: return "dut1.B";
    endcase
  endfunction

  function automatic logic [31:0] word_of(input int d, input logic [3:0] a);
    return {mdl[d][a][3], mdl[d][a][2], mdl[d][a][1], mdl[d][a][0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One edge of one configuration, computed from the behavioural rules on whole words and lanes.
  task automatic model(input int d, input logic rst, input logic wa, input logic wb,
                       input logic [3:0] bea, input logic [3:0] beb,
                       input logic [3:0] aa, input logic [3:0] ab,
                       input logic [31:0] da, input logic [31:0] db,
                       output logic [31:0] ea, output logic [31:0] eb, output logic ec);
    int depth;
    logic ina, inb, oka, okb, pa;
    logic [31:0] oa, ob;
    depth = (d == 0) ? DEPTH0 : DEPTH1;
    pa    = (d == 0);
    ina   = int'(aa) < depth;
    inb   = int'(ab) < depth;
    oka   = !rst && wa && ina;
    okb   = !rst && wb && inb;
    oa    = ina ? word_of(d, aa) : 32'h0;
    ob    = inb ? word_of(d, ab) : 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (oka && bea[k]) mdl[d][aa][k] = da[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      if (okb && beb[k] && !(oka && aa == ab && bea[k] && pa)) mdl[d][ab][k] = db[8*k +: 8];
    end
    ec = oka && okb && (aa == ab) && ((bea & beb) != 4'h0);
    if (d == 1) begin
      ea = ina ? word_of(d, aa) : 32'h0;
      eb = inb ? word_of(d, ab) : 32'h0;
    end else begin
      ea = oa;
      eb = ob;
    end
  endtask

  task automatic push_rd(input int p, input logic [31:0] v);
    rbuf[p][rwp[p] % 64] = v;
    rtag[p][rwp[p] % 64] = cyc;
    rwp[p]++;
  endtask

  task automatic step(input logic rst, input logic wa, input logic wb, input logic ra, input logic rb,
                      input logic [3:0] bea, input logic [3:0] beb,
                      input logic [3:0] aa, input logic [3:0] ab,
                      input logic [31:0] da, input logic [31:0] db);
    logic [31:0] ea0, eb0, ea1, eb1;
    logic ec0, ec1;
    reset = rst; write_A = wa; write_B = wb; read_A = ra; read_B = rb;
    be_A = bea; be_B = beb; addr_A = aa; addr_B = ab; data_wr_A = da; data_wr_B = db;
    model(0, rst, wa, wb, bea, beb, aa, ab, da, db, ea0, eb0, ec0);
    model(1, rst, wa, wb, bea, beb, aa, ab, da, db, ea1, eb1, ec1);
    @(posedge clk);
    cyc++;
    if (!rst && ra) begin
      push_rd(0, ea0);
      push_rd(2, ea1);
    end
    if (!rst && rb) begin
      push_rd(1, eb0);
      push_rd(3, eb1);
    end
    cbuf[0][cwp[0] % 64] = ec0;
    cwp[0]++;
    cbuf[1][cwp[1] % 64] = ec1;
    cwp[1]++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        if (reset) begin
          check({pname(p), " reset valid"}, {31'b0, v_w[p]}, 32'h0);
          check({pname(p), " reset data"}, rd_w[p], 32'h0);
          last[p] = 32'h0;
        end else if (v_w[p]) begin
          if (rrp[p] != rwp[p] && rtag[p][rrp[p] % 64] == cyc - (LAT - 1)) begin
            check({pname(p), " read data"}, rd_w[p], rbuf[p][rrp[p] % 64]);
            last[p] = rbuf[p][rrp[p] % 64];
            rrp[p]++;
          end else begin
            checks++;
            errors++;
            $display("FAIL %s unexpected valid: got 1 expected 0", pname(p));
          end
        end else if (rrp[p] != rwp[p] && rtag[p][rrp[p] % 64] <= cyc - (LAT - 1)) begin
          checks++;
          errors++;
          $display("FAIL %s missing valid: got 0 expected 1", pname(p));
          rrp[p]++;
        end else begin
          check({pname(p), " hold data"}, rd_w[p], last[p]);
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (cwp[d] - crp[d] >= LAT) begin
          check(d == 0 ? "dut0 collision" : "dut1 collision", {31'b0, c_w[d]},
                {31'b0, cbuf[d][crp[d] % 64]});
          crp[d]++;
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    mon_en = 1'b1;
    for (int p = 0; p < 4; p++) begin
      rwp[p]  = 0;
      rrp[p]  = 0;
      last[p] = 32'h0;
    end
    for (int d = 0; d < 2; d++) begin
      cwp[d] = 0;
      crp[d] = 0;
    end

    // reset with requests present: everything is dropped
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'd0, 4'd1, 32'hDEAD0000, 32'hBEEF0000);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'd2, 4'd3, 32'hDEAD0001, 32'hBEEF0001);

    // fill every word so no read ever sees unwritten contents
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'(i), 4'(i + 8), $urandom, $urandom);

    // basic ports
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'(i), 4'((i + 2) % 16), $urandom, $urandom);
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'(i), 4'((i + 2) % 16), 32'h0, 32'h0);

    // byte enables
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'd3, 4'd0, 32'h11223344, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0101, 4'h0, 4'd3, 4'd0, 32'hAABBCCDD, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'd3, 4'd3, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'd3, 4'd0, 32'hFFFFFFFF, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd3, 4'd0, 32'h0, 32'h0);

    // collisions: full overlap, then disjoint lanes
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 4'd5, 4'd5, 32'hA5A5A5A5, 32'h5B5B5B5B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'd5, 4'd5, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b1100, 4'd5, 4'd5, 32'hA5A5A5A5, 32'h5B5B5B5B);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'd5, 4'd5, 32'h0, 32'h0);

    // read-during-write, cross-port then same-port
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 4'd7, 4'd0, 32'h1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'd7, 4'd7, 32'h2, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 4'd0, 4'd7, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110, 4'h0, 4'd9, 4'd0, 32'hCAFEF00D, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'd9, 4'd0, 32'h0, 32'h0);

    // out-of-range addresses on the depth-12 instance
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'd13, 4'd14, 32'h12345678, 32'h9ABCDEF0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'd13, 4'd14, 32'h0, 32'h0);

    // streaming
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 4'(i), 4'(15 - i), 32'h0, 32'h0);

    // random traffic biased towards shared addresses
    for (int n = 0; n < 600; n++) begin
      logic [3:0] aa, ab;
      aa = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(4, 6)) : 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom_range(0, 15));
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), aa, ab, $urandom, $urandom);
    end

    for (int i = 0; i < 4; i++) idle();

    for (int p = 0; p < 4; p++)
      check({pname(p), " outstanding reads"}, 32'(rwp[p] - rrp[p]), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_dp_syncread_be.md
# sram_dp_syncread_be

Parametrised true dual-port synchronous-read SRAM with per-byte write enables, a selectable read-during-write mode, deterministic write-collision resolution and read-valid strobes. It is the next generation of the team's dual-port synchronous-read SRAM and is used as a generic scratchpad and buffer store inside datapath blocks. It is also the storage primitive for upcoming FIFO and line-buffer blocks.

## Interface
- WIDTH, 32: data word width in bits; must be a multiple of 8.
- DEPTH, 16: number of words.
- DEPTH_LOG, $clog2(DEPTH): address width.
- NB, WIDTH/8: byte lanes per word.
- RDW_MODE, RDW_READ_FIRST: read-during-write behaviour; one of RDW_READ_FIRST or RDW_WRITE_FIRST.
- WR_PRIORITY_A, 1: on a write collision, 1 means port A wins and 0 means port B wins.
- clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  reset, synchronous, active-high.
- write_A / write_B  input  1  write request for port A / port B.
- read_A / read_B  input  1  read request for port A / port B.
- be_A / be_B  input  NB  byte-lane write enables; bit k covers data bits [8k+7:8k].
- addr_A / addr_B  input  DEPTH_LOG  word address.
- data_wr_A / data_wr_B  input  WIDTH  write data.
- data_rd_A / data_rd_B  output  WIDTH  registered read data.
- valid_A / valid_B  output  1  read data valid strobe.
- collision  output  1  one-cycle pulse flagging a write-write collision.

## Operation
- **Reset:** data_rd_A, data_rd_B, valid_A, valid_B and collision reset to 0. Array contents are not reset and are undefined until written.
- **Write:** when write_X=1, lanes with be_X[k]=1 are written at addr_X on the edge. When be_X is all zero, nothing is written.
- **Read:** when read_X=1, the word at addr_X is registered onto data_rd_X on the edge, and valid_X=1 for exactly that cycle.
- **Read and write together:** read_X and write_X may both be asserted on one port in the same cycle.
- **Hold:** when no read is issued, data_rd_X holds its last value and valid_X=0.
- **Read-during-write (same address, same cycle, either port or cross-port):**
  - RDW_READ_FIRST returns the pre-write word.
  - RDW_WRITE_FIRST returns the post-write word. This is a byte-merged bypass: enabled lanes take the new data, other lanes keep the old contents. When both ports write, the bypass uses the resolved collision result.
- **Write collision:** both ports write the same address in the same cycle with overlapping byte enables.
  - Overlapping lanes take the data of the priority port.
  - Non-overlapping lanes take their own port's data.
  - collision=1 for one cycle after the edge.
  - When the same address is written with disjoint byte enables, both writes complete and collision stays 0.
- **Address range:** addresses ≥ DEPTH (non-power-of-two DEPTH) are ignored for writes. Reads of such addresses return 0 with valid asserted.
- **Reset mid-operation:** while reset=1, writes are blocked and outputs are forced to their reset values. A request presented in the reset cycle is dropped.

## Timing
- Write: data is visible to a read issued on the next cycle (READ_FIRST), or in the same cycle (WRITE_FIRST).
- Read latency: 1 cycle from request edge to data_rd_X/valid_X, or 2 cycles with the output register enabled.
- collision is registered and aligns with the read-data cycle of the colliding edge.
- No backpressure: a request is accepted every cycle on each port, and back-to-back reads return data on consecutive cycles.

## Configuration
- **SRAM_DP_OUTREG_EN defined:** an extra output register stage sits on data_rd_X, valid_X and collision.
  - Latency is 2 cycles.
  - The output stage resets to 0.
  - The RDW and collision semantics are unchanged; the results are simply delayed one cycle.
- **Undefined:** latency is 1 cycle and no extra flops are present.

## Structure
- Package sram_pkg holds:
  - the RDW_READ_FIRST / RDW_WRITE_FIRST constants (2-bit localparam encoding);
  - the byte-merge function, shared by the write path and the WRITE_FIRST bypass.
- Sub-module sram_rd_port, instantiated twice (A and B), contains:
  - the read address compare against both write ports;
  - the bypass mux;
  - the data/valid registers;
  - the optional output stage.
- The top level owns:
  - the array;
  - collision resolution and the lane-wise write muxing;
  - the collision flag register.

## Test plan
- **Reset:** drive reset=1 for 2 cycles with read_A=read_B=1 -> all outputs are 0 and valid never asserts. After release, writes are accepted on the first edge.
- **Basic ports:** WIDTH=8, DEPTH=16. For i=0..15, port A writes random data to i and port B writes random data to (i+2)%16, then both read back -> data matches every address. valid is high for exactly 1 cycle (2 cycles latency with SRAM_DP_OUTREG_EN).
- **Byte enables:**
  - WIDTH=32, address 3 holds 0x11223344.
  - Port A writes 0xAABBCCDD with be_A=4'b0101 -> reading address 3 returns 0x11BB33DD.
- **Collision:**
  - Both ports write address 5 with be=4'hF; A writes 0xA5A5A5A5, B writes 0x5B5B5B5B.
  - WR_PRIORITY_A=1 -> reads 0xA5A5A5A5 and collision pulses once.
  - Repeat with be_A=4'b0011 and be_B=4'b1100 -> reads 0x5B5BA5A5 with collision=0.
- **Read-during-write:**
  - Address 7 holds 0x01. Port A writes 0x02 while port B reads 7 in the same cycle.
  - RDW_READ_FIRST -> data_rd_B=0x01; RDW_WRITE_FIRST -> data_rd_B=0x02.
  - A read on the next cycle returns 0x02 in both modes.
- **Streaming:** 16 back-to-back reads on both ports with no idle cycles -> 16 consecutive valid cycles per port, with data in request order.
